dm_store_buf: RTL and testbench
===============================

DM_STORE_BUF -- requirements
Module: dm_store_buf

Interface
REQ-001 SHALL have clock port cpu_clk_50M (input, 1): the single clock; all state changes on its rising edge.
REQ-002 SHALL have reset port cpu_rst (input, 1): asynchronous, active-high reset.
REQ-003 SHALL have st_valid_i (input, 1): the MEM stage presents a store this cycle.
REQ-004 SHALL have st_ready_o (output, 1): the buffer can accept a store this cycle.
REQ-005 SHALL have st_word_i (input, 1): 1 = sw (word store), 0 = sb (byte store).
REQ-006 SHALL have st_addr_i (input, 32): store byte address.
REQ-007 SHALL have st_data_i (input, 32): store data; sb uses bits [7:0] only.
REQ-008 SHALL have ld_valid_i (input, 1) and ld_addr_i (input, 32): load address from the MEM stage, used for the hazard check.
REQ-009 SHALL have ld_stall_o (output, 1): the load conflicts with a pending store.
REQ-010 SHALL have dm_ce_o (output, 1), dm_we_o (output, 4), dm_addr_o (output, 32) and dm_din_o (output, 32): the data-memory write port.
REQ-011 SHALL have dm_ack_i (input, 1): data memory has completed the presented write.
REQ-012 SHALL have empty_o (output, 1): no stores are pending.

Function
REQ-013 SHALL be a 4-entry FIFO; each entry holds a word address, a 4-bit byte-write enable and 32-bit formatted data.
- Pointers: 2 bits, wrap 3 -> 0.
- Count: 3 bits, range 0..4.
REQ-014 SHALL drive st_ready_o = (count != 4); a store is accepted when st_valid_i & st_ready_o.
- A pop in the same cycle does not raise st_ready_o when full.
REQ-015 SHALL format a word store (sw) as follows:
- Enable = 4'b1111.
- Data is byte-swapped: {d[7:0], d[15:8], d[23:16], d[31:24]}.
REQ-016 SHALL format a byte store (sb) as follows:
- Data = {4{d[7:0]}}.
- Enable is one-hot from the address offset: offset 0 -> 4'b1000, 1 -> 4'b0100, 2 -> 4'b0010, 3 -> 4'b0001.
REQ-017 SHALL store addr[31:2] only; dm_addr_o = {entry_addr, 2'b00}.
REQ-018 SHALL implement a drain FSM with states IDLE and WRITE.
- IDLE -> WRITE on the edge where count becomes nonzero.
- In WRITE with dm_ack_i = 1: pop the head; stay in WRITE if entries remain after the pop, including an entry pushed in the same cycle; otherwise go to IDLE.
REQ-019 SHALL, in WRITE, drive dm_ce_o = 1 and dm_we_o/dm_addr_o/dm_din_o from the head entry, held stable until dm_ack_i.
- In IDLE: dm_ce_o = 0 and dm_we_o = 0.
REQ-020 SHALL have a latency of one cycle: a store accepted at edge N into an empty buffer appears on dm_* in the cycle after edge N.
REQ-021 SHALL support a simultaneous push and pop: count is unchanged and both pointers advance.
REQ-022 SHALL drive ld_stall_o combinationally as ld_valid_i & (a match on ld_addr_i[31:2]).
- A match against any valid entry counts, including the head currently being written.
- A match against an incoming store accepted the same cycle also counts.
REQ-023 SHALL drive empty_o = (count == 0) & (state == IDLE).
REQ-024 SHALL preserve store order: writes reach data memory strictly in acceptance order.

Reset
REQ-025 SHALL, while cpu_rst = 1 (asynchronously), force the following:
- State IDLE, count 0, pointers 0, all entries invalid.
- dm_ce_o = 0, dm_we_o = 0, dm_addr_o = 0, dm_din_o = 0.
- st_ready_o = 0, ld_stall_o = 0, empty_o = 1.
REQ-026 SHALL discard pending stores on reset mid-operation; dm_ce_o drops without waiting for dm_ack_i.
REQ-027 SHALL release reset into an empty, IDLE, ready buffer.

Structure
REQ-028 SHALL define the byte-enable encodings, FIFO depth (4), state encodings and bus widths as constants in the shared defines file.
REQ-029 SHALL place storage plus pointers in one natural sub-module, dm_store_fifo; formatting, hazard compare and the FSM sit in dm_store_buf.

Verification
REQ-030 Word store: sw addr 0x00000010, data 0x11223344, buffer empty -> next cycle dm_ce_o = 1, dm_we_o = 4'b1111, dm_addr_o = 0x10, dm_din_o = 0x44332211; ack one cycle -> dm_ce_o = 0 and empty_o = 1 after the next edge.
REQ-031 Byte store: sb addr 0x00000013, data 0x000000AB -> dm_we_o = 4'b0001, dm_addr_o = 0x10, dm_din_o = 0xABABABAB.
REQ-032 Full and order: 4 stores with dm_ack_i = 0 -> st_ready_o = 0 after the 4th and a 5th st_valid_i is not accepted; ack once -> st_ready_o = 1 next cycle; the five writes appear in acceptance order.
REQ-033 Load hazard: sb 0x16 pending, load ld_addr_i = 0x14 -> ld_stall_o = 1 until the ack pops it, then 0; load 0x20 -> ld_stall_o = 0 throughout.
REQ-034 Reset mid-write: cpu_rst pulsed while in WRITE with 3 entries -> dm_ce_o = 0 immediately, empty_o = 1, no further writes after release.
REQ-035 Push and pop together: push while acking with count = 2 -> count stays 2, the next head is presented next cycle, no gap in dm_ce_o.

Source files
------------

// File: rtl/dm_store_buf_pkg.sv
// Shared constants, types and the store-formatting helper for the data-memory store buffer.
package dm_store_buf_pkg;

    // Bus widths
    localparam int ADDR_W  = 32;
    localparam int DATA_W  = 32;
    localparam int BE_W    = 4;
    localparam int WADDR_W = ADDR_W - 2;

    // FIFO geometry: 4 entries, 2-bit wrapping pointers, 3-bit count (0..4)
    localparam int DEPTH = 4;
    localparam int PTR_W = 2;
    localparam int CNT_W = 3;
    localparam logic [CNT_W-1:0] CNT_EMPTY = 3'd0;
    localparam logic [CNT_W-1:0] CNT_ONE   = 3'd1;
    localparam logic [CNT_W-1:0] CNT_FULL  = 3'd4;

    // Byte-write enables; byte lane 0 of the address maps to the MSB of the enable
    localparam logic [BE_W-1:0] BE_NONE = 4'b0000;
    localparam logic [BE_W-1:0] BE_WORD = 4'b1111;
    localparam logic [BE_W-1:0] BE_OFF0 = 4'b1000;
    localparam logic [BE_W-1:0] BE_OFF1 = 4'b0100;
    localparam logic [BE_W-1:0] BE_OFF2 = 4'b0010;
    localparam logic [BE_W-1:0] BE_OFF3 = 4'b0001;

    // Drain FSM states
    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_WRITE = 1'b1
    } drain_state_t;

    // One buffered store, already formatted for the memory write port
    typedef struct packed {
        logic [WADDR_W-1:0] waddr;
        logic [BE_W-1:0]    be;
        logic [DATA_W-1:0]  data;
    } sb_entry_t;

    // Turn a raw MEM-stage store into a memory-port entry.
    // Word stores are byte-swapped (memory is big-endian in lane order);
    // byte stores replicate the byte and select one lane from the offset.
    function automatic sb_entry_t fmt_store(
        input logic              is_word,
        input logic [ADDR_W-1:0] addr,
        input logic [DATA_W-1:0] d
    );
        sb_entry_t e;
        e.waddr = addr[ADDR_W-1:2];
        if (is_word) begin
            e.be   = BE_WORD;
            e.data = {d[7:0], d[15:8], d[23:16], d[31:24]};
        end else begin
            e.data = {4{d[7:0]}};
            case (addr[1:0])
                2'd0:    e.be = BE_OFF0;
                2'd1:    e.be = BE_OFF1;
                2'd2:    e.be = BE_OFF2;
                default: e.be = BE_OFF3;
            endcase
        end
        return e;
    endfunction

endpackage

// File: rtl/dm_store_fifo.sv
// Four-entry store FIFO: entry storage, wrapping pointers, occupancy count and
// per-entry valid flags. Word addresses of all slots are exposed for hazard checks.
module dm_store_fifo
    import dm_store_buf_pkg::*;
(
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             i_push,
    input  sb_entry_t                        i_entry,
    input  logic                             i_pop,
    output sb_entry_t                        o_head,
    output logic [CNT_W-1:0]                 o_count,
    output logic [DEPTH-1:0]                 o_valid,
    output logic [DEPTH-1:0][WADDR_W-1:0]    o_waddr
);

    sb_entry_t          r_mem [DEPTH];
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [CNT_W-1:0]   r_count;
    logic [DEPTH-1:0]   r_valid;

    logic               w_push;
    logic               w_pop;

    // Guard against overflow/underflow so the caller cannot corrupt the count
    assign w_push = i_push & (r_count != CNT_FULL);
    assign w_pop  = i_pop  & (r_count != CNT_EMPTY);

    // Pointer and occupancy bookkeeping; push and pop together leave the count unchanged
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= CNT_EMPTY;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Entry payload needs no reset: it is only observed while its valid flag is set
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_entry;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_slot
            // Per-slot valid flag; push and pop never target the same slot in one cycle
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_valid[gi] <= 1'b0;
                end else if (w_push && (r_wr_ptr == PTR_W'(gi))) begin
                    r_valid[gi] <= 1'b1;
                end else if (w_pop && (r_rd_ptr == PTR_W'(gi))) begin
                    r_valid[gi] <= 1'b0;
                end
            end
            assign o_waddr[gi] = r_mem[gi].waddr;
        end
    endgenerate

    assign o_head  = r_mem[r_rd_ptr];
    assign o_count = r_count;
    assign o_valid = r_valid;

endmodule

// File: rtl/dm_store_buf.sv
// Data-memory store buffer: formats MEM-stage stores, queues them in a 4-deep FIFO,
// drains them in order to the data-memory write port and flags load/store hazards.
module dm_store_buf
    import dm_store_buf_pkg::*;
(
    input  logic                cpu_clk_50M,
    input  logic                cpu_rst,
    input  logic                st_valid_i,
    output logic                st_ready_o,
    input  logic                st_word_i,
    input  logic [ADDR_W-1:0]   st_addr_i,
    input  logic [DATA_W-1:0]   st_data_i,
    input  logic                ld_valid_i,
    input  logic [ADDR_W-1:0]   ld_addr_i,
    output logic                ld_stall_o,
    output logic                dm_ce_o,
    output logic [BE_W-1:0]     dm_we_o,
    output logic [ADDR_W-1:0]   dm_addr_o,
    output logic [DATA_W-1:0]   dm_din_o,
    input  logic                dm_ack_i,
    output logic                empty_o
);

    drain_state_t                   r_state;
    drain_state_t                   w_state_next;

    sb_entry_t                      w_entry;
    sb_entry_t                      w_head;
    logic [CNT_W-1:0]               w_count;
    logic [DEPTH-1:0]               w_valid;
    logic [DEPTH-1:0][WADDR_W-1:0]  w_waddr;
    logic                           w_st_ready;
    logic                           w_push;
    logic                           w_pop;
    logic [DEPTH-1:0]               w_match;
    logic                           w_in_match;
    logic                           w_ld_unused;

    // Ready is held low while reset is asserted; a same-cycle pop does not help a full buffer
    assign w_st_ready = ~cpu_rst & (w_count != CNT_FULL);
    assign w_push     = st_valid_i & w_st_ready;
    assign w_pop      = (r_state == ST_WRITE) & dm_ack_i;
    assign w_entry    = fmt_store(st_word_i, st_addr_i, st_data_i);

    dm_store_fifo u_fifo (
        .clk     (cpu_clk_50M),
        .rst     (cpu_rst),
        .i_push  (w_push),
        .i_entry (w_entry),
        .i_pop   (w_pop),
        .o_head  (w_head),
        .o_count (w_count),
        .o_valid (w_valid),
        .o_waddr (w_waddr)
    );

    // Drain state register
    always_ff @(posedge cpu_clk_50M or posedge cpu_rst) begin
        if (cpu_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Drain next-state and write-port outputs; the head is presented until acknowledged
    always_comb begin
        w_state_next = r_state;
        dm_ce_o      = 1'b0;
        dm_we_o      = BE_NONE;
        dm_addr_o    = '0;
        dm_din_o     = '0;
        case (r_state)
            ST_IDLE: begin
                if (w_push) begin
                    w_state_next = ST_WRITE;
                end
            end
            ST_WRITE: begin
                dm_ce_o   = 1'b1;
                dm_we_o   = w_head.be;
                dm_addr_o = {w_head.waddr, 2'b00};
                dm_din_o  = w_head.data;
                // Leave only when the last entry is popped and nothing arrives behind it
                if (dm_ack_i && (w_count == CNT_ONE) && !w_push) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // Word-address compare of the load against every queued store, head included
    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_hazard
            assign w_match[gi] = w_valid[gi] & (w_waddr[gi] == ld_addr_i[ADDR_W-1:2]);
        end
    endgenerate

    // A store being accepted this cycle is also a conflict for the load
    assign w_in_match = w_push & (st_addr_i[ADDR_W-1:2] == ld_addr_i[ADDR_W-1:2]);
    assign ld_stall_o = ~cpu_rst & ld_valid_i & ((|w_match) | w_in_match);

    // Byte offset of the load is irrelevant at word granularity
    assign w_ld_unused = ^ld_addr_i[1:0];

    assign st_ready_o = w_st_ready;
    assign empty_o    = (w_count == CNT_EMPTY) & (r_state == ST_IDLE);

endmodule

// File: tb/tb_dm_store_buf.sv
// Directed self-checking bench for dm_store_buf.
module tb_dm_store_buf;

    logic        clk = 1'b0;
    logic        rst;
    logic        st_valid;
    logic        st_ready;
    logic        st_word;
    logic [31:0] st_addr;
    logic [31:0] st_data;
    logic        ld_valid;
    logic [31:0] ld_addr;
    logic        ld_stall;
    logic        dm_ce;
    logic [3:0]  dm_we;
    logic [31:0] dm_addr;
    logic [31:0] dm_din;
    logic        dm_ack;
    logic        empty;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    dm_store_buf dut (
        .cpu_clk_50M (clk),
        .cpu_rst     (rst),
        .st_valid_i  (st_valid),
        .st_ready_o  (st_ready),
        .st_word_i   (st_word),
        .st_addr_i   (st_addr),
        .st_data_i   (st_data),
        .ld_valid_i  (ld_valid),
        .ld_addr_i   (ld_addr),
        .ld_stall_o  (ld_stall),
        .dm_ce_o     (dm_ce),
        .dm_we_o     (dm_we),
        .dm_addr_o   (dm_addr),
        .dm_din_o    (dm_din),
        .dm_ack_i    (dm_ack),
        .empty_o     (empty)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic chk_dm(input string tag, input logic ce, input logic [3:0] we,
                          input logic [31:0] a, input logic [31:0] d);
        chk({tag, ".ce"},   {31'd0, dm_ce}, {31'd0, ce});
        chk({tag, ".we"},   {28'd0, dm_we}, {28'd0, we});
        chk({tag, ".addr"}, dm_addr, a);
        chk({tag, ".din"},  dm_din, d);
    endtask

    // Advance past the next rising edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic word, input logic [31:0] a, input logic [31:0] d);
        st_valid = 1'b1;
        st_word  = word;
        st_addr  = a;
        st_data  = d;
        $display("store offered: %s addr=0x%08h data=0x%08h", word ? "sw" : "sb", a, d);
    endtask

    initial begin
        rst = 1'b1; st_valid = 1'b0; st_word = 1'b0; st_addr = '0; st_data = '0;
        ld_valid = 1'b0; ld_addr = '0; dm_ack = 1'b0;

        // Reset state, with a store and a matching load offered
        #2;
        st_valid = 1'b1; st_word = 1'b1; ld_valid = 1'b1;
        #1;
        chk("rst.ready", {31'd0, st_ready}, 32'd0);
        chk("rst.stall", {31'd0, ld_stall}, 32'd0);
        chk("rst.empty", {31'd0, empty}, 32'd1);
        chk_dm("rst", 1'b0, 4'b0000, 32'h0, 32'h0);
        st_valid = 1'b0; ld_valid = 1'b0;
        step(); step();
        rst = 1'b0;
        #1;
        chk("rel.ready", {31'd0, st_ready}, 32'd1);
        chk("rel.empty", {31'd0, empty}, 32'd1);

        // Word store
        offer(1'b1, 32'h0000_0010, 32'h1122_3344);
        step();
        st_valid = 1'b0;
        #1;
        chk_dm("sw", 1'b1, 4'b1111, 32'h10, 32'h4433_2211);
        chk("sw.empty", {31'd0, empty}, 32'd0);
        dm_ack = 1'b1;
        step();
        dm_ack = 1'b0;
        #1;
        chk("sw.done.ce", {31'd0, dm_ce}, 32'd0);
        chk("sw.done.empty", {31'd0, empty}, 32'd1);

        // Byte store at offset 3
        offer(1'b0, 32'h0000_0013, 32'h0000_00AB);
        step();
        st_valid = 1'b0;
        #1;
        chk_dm("sb3", 1'b1, 4'b0001, 32'h10, 32'hABAB_ABAB);
        dm_ack = 1'b1;
        step();
        dm_ack = 1'b0;
        #1;
        chk("sb3.done.empty", {31'd0, empty}, 32'd1);

        // Fill to four, fifth stalls, then drain in order
        offer(1'b0, 32'h0000_0100, 32'h0000_0001); step();
        offer(1'b0, 32'h0000_0101, 32'h0000_0002); step();
        offer(1'b0, 32'h0000_0102, 32'h0000_0003); step();
        offer(1'b1, 32'h0000_0104, 32'hAABB_CCDD); step();
        offer(1'b1, 32'h0000_0200, 32'h1234_5678);
        #1;
        chk("full.ready", {31'd0, st_ready}, 32'd0);
        chk_dm("full.h1", 1'b1, 4'b1000, 32'h100, 32'h0101_0101);
        step();
        chk("full.hold.ready", {31'd0, st_ready}, 32'd0);
        chk_dm("full.hold.h1", 1'b1, 4'b1000, 32'h100, 32'h0101_0101);
        dm_ack = 1'b1;
        step();
        dm_ack = 1'b0;
        #1;
        chk("pop1.ready", {31'd0, st_ready}, 32'd1);
        chk_dm("pop1.h2", 1'b1, 4'b0100, 32'h100, 32'h0202_0202);
        step();
        st_valid = 1'b0;
        #1;
        chk("fifth.ready", {31'd0, st_ready}, 32'd0);
        dm_ack = 1'b1;
        step();
        chk_dm("ord.h3", 1'b1, 4'b0010, 32'h100, 32'h0303_0303);
        step();
        chk_dm("ord.h4", 1'b1, 4'b1111, 32'h104, 32'hDDCC_BBAA);
        step();
        chk_dm("ord.h5", 1'b1, 4'b1111, 32'h200, 32'h7856_3412);
        step();
        dm_ack = 1'b0;
        #1;
        chk("ord.done.ce", {31'd0, dm_ce}, 32'd0);
        chk("ord.done.empty", {31'd0, empty}, 32'd1);

        // Load hazard
        offer(1'b0, 32'h0000_0016, 32'h0000_005A);
        ld_valid = 1'b1; ld_addr = 32'h0000_0014;
        #1;
        chk("haz.incoming", {31'd0, ld_stall}, 32'd1);
        ld_addr = 32'h0000_0020;
        #1;
        chk("haz.in.other", {31'd0, ld_stall}, 32'd0);
        ld_addr = 32'h0000_0014;
        step();
        st_valid = 1'b0;
        #1;
        chk("haz.pending", {31'd0, ld_stall}, 32'd1);
        chk_dm("sb2", 1'b1, 4'b0010, 32'h14, 32'h5A5A_5A5A);
        step();
        chk("haz.held", {31'd0, ld_stall}, 32'd1);
        ld_addr = 32'h0000_0020;
        #1;
        chk("haz.other", {31'd0, ld_stall}, 32'd0);
        ld_valid = 1'b0; ld_addr = 32'h0000_0014;
        #1;
        chk("haz.novalid", {31'd0, ld_stall}, 32'd0);
        ld_valid = 1'b1;
        dm_ack = 1'b1;
        step();
        dm_ack = 1'b0;
        #1;
        chk("haz.popped", {31'd0, ld_stall}, 32'd0);
        ld_valid = 1'b0;

        // Reset in the middle of a write with three entries queued
        offer(1'b1, 32'h0000_0400, 32'h0000_0001); step();
        offer(1'b1, 32'h0000_0404, 32'h0000_0002); step();
        offer(1'b1, 32'h0000_0408, 32'h0000_0003); step();
        st_valid = 1'b0;
        #1;
        chk("mid.ce", {31'd0, dm_ce}, 32'd1);
        #1;
        rst = 1'b1;
        #1;
        chk_dm("mid.rst", 1'b0, 4'b0000, 32'h0, 32'h0);
        chk("mid.rst.empty", {31'd0, empty}, 32'd1);
        chk("mid.rst.ready", {31'd0, st_ready}, 32'd0);
        step();
        rst = 1'b0;
        dm_ack = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("post.ce", {31'd0, dm_ce}, 32'd0);
            chk("post.empty", {31'd0, empty}, 32'd1);
        end
        dm_ack = 1'b0;
        #1;
        chk("post.ready", {31'd0, st_ready}, 32'd1);

        // Push and pop in the same cycle with two entries queued
        offer(1'b1, 32'h0000_0300, 32'h0102_0304); step();
        offer(1'b1, 32'h0000_0304, 32'h0506_0708); step();
        st_valid = 1'b0;
        #1;
        chk_dm("pp.a", 1'b1, 4'b1111, 32'h300, 32'h0403_0201);
        offer(1'b1, 32'h0000_0308, 32'h090A_0B0C);
        dm_ack = 1'b1;
        step();
        st_valid = 1'b0;
        #1;
        chk_dm("pp.b", 1'b1, 4'b1111, 32'h304, 32'h0807_0605);
        chk("pp.ready", {31'd0, st_ready}, 32'd1);
        step();
        chk_dm("pp.c", 1'b1, 4'b1111, 32'h308, 32'h0C0B_0A09);
        step();
        dm_ack = 1'b0;
        #1;
        chk("pp.done.ce", {31'd0, dm_ce}, 32'd0);
        chk("pp.done.empty", {31'd0, empty}, 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
